// File: rtl/pulse_stretcher_pkg.sv
// Shared state encoding and default sizing for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_COUNT_MAX   = 2**16 - 1;
  localparam int DEF_COUNT_WIDTH = 16;
  localparam int DEF_GAP_MAX     = 2**12 - 1;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event strobes in, stretched pulses and status out; one bit per channel.
interface pulse_stretcher_if #(
  parameter int N_CH = pulse_stretcher_pkg::DEF_N_CH
);
  logic [N_CH-1:0] din;
  logic [N_CH-1:0] dout;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] overrun;

  modport master (output din, input dout, busy, overrun);
  modport slave  (input din, output dout, busy, overrun);
endinterface

// File: rtl/stretch_channel.sv
// One pulse-stretcher channel: IDLE -> HOLD (COUNT_MAX+1 high) -> GAP (GAP_MAX+1 low).
// PULSE_RETRIGGER_EN: an event during HOLD restarts the high time instead of being dropped.
module stretch_channel
  import pulse_stretcher_pkg::*;
#(
  parameter int COUNT_MAX   = DEF_COUNT_MAX,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int GAP_MAX     = DEF_GAP_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o,
  output logic busy_o,
  output logic overrun_o
);

  localparam logic [COUNT_WIDTH-1:0] CMAX = COUNT_WIDTH'(COUNT_MAX);
  localparam logic [COUNT_WIDTH-1:0] GMAX = COUNT_WIDTH'(GAP_MAX);
  localparam logic [COUNT_WIDTH-1:0] ONE  = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   din_q;
  logic                   dout_q, dout_d;
  logic                   busy_q, busy_d;
  logic                   ovr_q, ovr_d;
  logic                   ev, drop;

  assign ev = din_i & ~din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      din_q   <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      din_q   <= din_i;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ev) state_d = HOLD;
      end
      HOLD: begin
`ifdef PULSE_RETRIGGER_EN
        if (ev) begin
          cnt_d = '0;
        end else if (cnt_q == CMAX) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
`else
        drop = ev;
        if (cnt_q == CMAX) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
`endif
      end
      GAP: begin
        if (cnt_q == GMAX) begin
          // An event landing on the expiry cycle counts as the pending one.
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = (pend_q || ev) ? HOLD : IDLE;
          drop    = ev && pend_q;
        end else begin
          cnt_d = cnt_q + ONE;
          if (ev) begin
            if (pend_q) drop   = 1'b1;
            else        pend_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    dout_d = (state_d == HOLD);
    busy_d = (state_d != IDLE);
    ovr_d  = drop;
  end

  assign dout_o    = dout_q;
  assign busy_o    = busy_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/pulse_stretcher.sv
// N_CH independent pulse stretchers; set PULSE_RETRIGGER_EN to let events in HOLD extend the pulse.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int COUNT_MAX   = DEF_COUNT_MAX,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int GAP_MAX     = DEF_GAP_MAX
) (
  input  logic             clk,
  input  logic             rst,
  pulse_stretcher_if.slave bus
);

  logic [N_CH-1:0] dout_w, busy_w, ovr_w;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    stretch_channel #(
      .COUNT_MAX  (COUNT_MAX),
      .COUNT_WIDTH(COUNT_WIDTH),
      .GAP_MAX    (GAP_MAX)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .din_i    (bus.din[g]),
      .dout_o   (dout_w[g]),
      .busy_o   (busy_w[g]),
      .overrun_o(ovr_w[g])
    );
  end

  assign bus.dout    = dout_w;
  assign bus.busy    = busy_w;
  assign bus.overrun = ovr_w;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed + random bench for pulse_stretcher (N_CH=2, COUNT_MAX=7, GAP_MAX=3) against an interval model.
module tb_pulse_stretcher;

  localparam int NC = 2;
  localparam int C  = 7;
  localparam int G  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pulse_stretcher_if #(.N_CH(NC)) bus ();

  pulse_stretcher #(
    .N_CH(NC), .COUNT_MAX(C), .COUNT_WIDTH(16), .GAP_MAX(G)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int t = 0;
  // Model: each channel is an interval [start, hi_end] high, then (hi_end, gap_end] forced low.
  int start_c[NC], hi_end[NC], gap_end[NC];
  bit pend[NC];
  logic [NC-1:0] prev_d, exp_ovr;
  int hi0, busy0, ovr0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      start_c[c] = -1000; hi_end[c] = -1000; gap_end[c] = -1000; pend[c] = 1'b0;
    end
    prev_d  = '0;
    exp_ovr = '0;
  endtask

  task automatic new_pulse(input int c);
    start_c[c] = t;
    hi_end[c]  = t + C;
    gap_end[c] = t + C + G + 1;
  endtask

  task automatic model_edge(input logic [NC-1:0] d);
    bit ev, inh, ing;
    t++;
    if (rst) begin
      model_clear();
      return;
    end
    for (int c = 0; c < NC; c++) begin
      ev  = d[c] && !prev_d[c];
      inh = (t - 1 >= start_c[c]) && (t - 1 <= hi_end[c]);
      ing = (t - 1 > hi_end[c]) && (t - 1 <= gap_end[c]);
      exp_ovr[c] = 1'b0;
      if (inh) begin
        if (ev) begin
`ifdef PULSE_RETRIGGER_EN
          hi_end[c]  = t + C;
          gap_end[c] = t + C + G + 1;
`else
          exp_ovr[c] = 1'b1;
`endif
        end
      end else if (ing) begin
        if (t - 1 == gap_end[c]) begin
          if (pend[c] || ev) new_pulse(c);
          exp_ovr[c] = ev && pend[c];
          pend[c] = 1'b0;
        end else if (ev) begin
          if (pend[c]) exp_ovr[c] = 1'b1;
          else         pend[c] = 1'b1;
        end
      end else if (ev) begin
        new_pulse(c);
      end
    end
    prev_d = d;
  endtask

  task automatic tick(input logic [NC-1:0] d);
    logic [NC-1:0] ed, eb;
    bus.din = d;
    @(posedge clk);
    model_edge(d);
    #1;
    for (int c = 0; c < NC; c++) begin
      ed[c] = (t >= start_c[c]) && (t <= hi_end[c]);
      eb[c] = (t >= start_c[c]) && (t <= gap_end[c]);
    end
    chk("dout", int'(bus.dout), int'(ed));
    chk("busy", int'(bus.busy), int'(eb));
    chk("overrun", int'(bus.overrun), int'(exp_ovr));
    if (bus.dout[0])    hi0++;
    if (bus.busy[0])    busy0++;
    if (bus.overrun[0]) ovr0++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0);
  endtask

  task automatic clr_meas();
    hi0 = 0; busy0 = 0; ovr0 = 0;
  endtask

  initial begin
    bus.din = '0;
    model_clear();
    #2 rst = 1'b1;
    #1;
    chk("reset_dout", int'(bus.dout), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_ovr", int'(bus.overrun), 0);
    tick('0); tick('0);
    rst = 1'b0;
    idle(3);

    // Single strobe: 8 high, 4 low, 12 busy, channel 1 quiet.
    clr_meas();
    tick(2'b01);
    idle(20);
    chk("single_hi", hi0, C + 1);
    chk("single_busy", busy0, C + G + 2);
    chk("single_ovr", ovr0, 0);

    // Level held for 50 cycles is one event.
    clr_meas();
    for (int i = 0; i < 50; i++) tick(2'b01);
    idle(15);
    chk("level_hi", hi0, C + 1);
    chk("level_ovr", ovr0, 0);

    // Second strobe 5 cycles into HOLD.
    clr_meas();
    tick(2'b01); idle(4); tick(2'b01);
    idle(25);
`ifdef PULSE_RETRIGGER_EN
    chk("retrig_hi", hi0, 13);
    chk("retrig_ovr", ovr0, 0);
`else
    chk("hold_drop_hi", hi0, C + 1);
    chk("hold_drop_ovr", ovr0, 1);
`endif

    // Two strobes during GAP: first queued, second overruns.
    clr_meas();
    tick(2'b01); idle(8); tick(2'b01); tick('0); tick(2'b01);
    idle(30);
    chk("gap_two_hi", hi0, 2 * (C + 1));
    chk("gap_two_ovr", ovr0, 1);

    // Strobe exactly on the GAP expiry cycle re-enters HOLD without overrun.
    clr_meas();
    tick(2'b01); idle(11); tick(2'b01);
    idle(30);
    chk("gap_exp_hi", hi0, 2 * (C + 1));
    chk("gap_exp_ovr", ovr0, 0);

    // Asynchronous reset mid-HOLD.
    tick(2'b11); idle(3);
    chk("pre_rst_dout", int'(bus.dout), 3);
    rst = 1'b1;
    #2;
    chk("async_dout", int'(bus.dout), 0);
    chk("async_busy", int'(bus.busy), 0);
    tick('0); tick('0);
    rst = 1'b0;
    clr_meas();
    tick(2'b01);
    idle(20);
    chk("post_rst_hi", hi0, C + 1);

    // Random traffic on both channels.
    for (int i = 0; i < 400; i++) begin
      logic [NC-1:0] d;
      for (int c = 0; c < NC; c++) d[c] = ($urandom_range(0, 3) == 0);
      tick(d);
    end
    idle(20);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter N_CH, default 4: number of independent channels.
REQ-002 Parameter COUNT_MAX, default 2**16-1: sets the high-time length; output high for COUNT_MAX+1 cycles.
REQ-003 Parameter COUNT_WIDTH, default 16: counter width; must satisfy COUNT_MAX < 2**COUNT_WIDTH.
REQ-004 Parameter GAP_MAX, default 2**12-1: sets the forced low time; output low for GAP_MAX+1 cycles after each pulse, GAP_MAX < 2**COUNT_WIDTH.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 din  input  N_CH  short internal event strobes (one bit per channel), synchronous to clk.
REQ-008 dout  output  N_CH  stretched, human-visible pulses (LED/pin drive), registered.
REQ-009 busy  output  N_CH  channel not in IDLE, registered.
REQ-010 overrun  output  N_CH  one-cycle strobe: event dropped, registered.

Function
REQ-011 Channels SHALL be fully independent; no shared counters or arbitration.
REQ-012 Each channel SHALL register din into din_q; rising event = din & ~din_q, evaluated each cycle.
REQ-013 Per-channel FSM states SHALL be IDLE, HOLD, GAP.
REQ-014 IDLE: dout=0, counter held 0; event at edge k -> HOLD, dout=1 from edge k onward (one-cycle latency from din sampled high).
REQ-015 HOLD: dout=1, counter increments by 1 per cycle; at counter==COUNT_MAX -> GAP, counter cleared, dout=0 next cycle; total high time exactly COUNT_MAX+1 cycles.
REQ-016 GAP: dout=0, counter increments; at counter==GAP_MAX -> HOLD (counter 0, dout=1) if pending set, else IDLE; pending cleared on that transition.
REQ-017 Event in GAP SHALL set a one-deep pending flag; event in GAP with pending already set SHALL assert overrun for one cycle, pending unchanged.
REQ-018 Event in the same cycle as GAP expiry SHALL be treated as pending (direct re-entry to HOLD), no overrun.
REQ-019 Event in HOLD: behaviour per REQ-024/REQ-025.
REQ-020 din held high continuously SHALL yield exactly one event (level, not edge, is ignored).
REQ-021 busy SHALL be 1 in HOLD and GAP, 0 in IDLE.
REQ-022 Counter SHALL never wrap; comparisons use == against the parameter.

Reset
REQ-023 rst asserted at any time SHALL force IDLE, counter=0, din_q=0, pending=0, dout=0, busy=0, overrun=0 immediately; pulses in flight are truncated; first event after release starts a full pulse.

Configuration
REQ-024 With PULSE_RETRIGGER_EN defined: event in HOLD SHALL reset counter to 0, extending high time to COUNT_MAX+1 cycles after that event; no overrun.
REQ-025 Without PULSE_RETRIGGER_EN: event in HOLD SHALL be dropped and assert overrun for one cycle; counter unaffected.

Structure
REQ-026 Package pulse_stretcher_pkg SHALL hold the state encoding (IDLE=2'd0, HOLD=2'd1, GAP=2'd2) and default parameter constants.
REQ-027 Sub-module stretch_channel SHALL implement one channel; pulse_stretcher SHALL instantiate N_CH copies via generate.

Verification (bench with COUNT_MAX=7, GAP_MAX=3, N_CH=2)
REQ-028 Single 1-cycle din[0] strobe -> dout[0] high exactly 8 cycles starting one edge later, low 4 cycles, busy 12 cycles, channel 1 unaffected.
REQ-029 din[0] held high 50 cycles -> exactly one 8-cycle pulse, no overrun.
REQ-030 Strobes 5 cycles apart -> without PULSE_RETRIGGER_EN: one 8-cycle pulse plus one overrun strobe; with it: 13-cycle high time, no overrun.
REQ-031 Two strobes during GAP -> first queued (second 8-cycle pulse follows 4-cycle gap), second gives overrun=1 for one cycle.
REQ-032 rst asserted mid-HOLD (cycle 3) -> dout, busy drop without waiting for clk; strobe after release gives full 8-cycle pulse.
